// File: rtl/rect_fill_engine.sv
// Rectangle fill engine: walks a w x h rectangle row-major from a latched origin, one pixel per cycle.
// Optional macro RECT_CLIP_EN suppresses plot for pixels outside SCREEN_W x SCREEN_H.
module rect_fill_engine #(
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int C_W      = 3,
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic [X_W-1:0] data_in,
    input  logic           ld_x,
    input  logic           ld_y,
    input  logic           start_count,
    input  logic [X_W-1:0] rect_w,
    input  logic [Y_W-1:0] rect_h,
    input  logic [C_W-1:0] colour_in,
    output logic [X_W-1:0] x_out,
    output logic [Y_W-1:0] y_out,
    output logic [C_W-1:0] colour_out,
    output logic           plot,
    output logic           busy,
    output logic           done
);

    // state  | meaning
    // S_IDLE | waiting for start_count; origin loads accepted
    // S_DRAW | one pixel per cycle from the snapshot
    // S_DONE | single-cycle done pulse, then back to S_IDLE
    typedef enum logic [1:0] {S_IDLE, S_DRAW, S_DONE} state_t;

    state_t         state_q, state_d;
    logic [X_W-1:0] x0_q, x0_d, xs_q, xs_d, w_q, w_d, cx_q, cx_d;
    logic [Y_W-1:0] y0_q, y0_d, ys_q, ys_d, h_q, h_d, cy_q, cy_d;
    logic [C_W-1:0] col_q, col_d;
    logic           last_col, last_row, draw;
    logic [X_W-1:0] x_sum;
    logic [Y_W-1:0] y_sum;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            x0_q    <= '0;
            y0_q    <= '0;
            xs_q    <= '0;
            ys_q    <= '0;
            w_q     <= '0;
            h_q     <= '0;
            cx_q    <= '0;
            cy_q    <= '0;
            col_q   <= '0;
        end else begin
            state_q <= state_d;
            x0_q    <= x0_d;
            y0_q    <= y0_d;
            xs_q    <= xs_d;
            ys_q    <= ys_d;
            w_q     <= w_d;
            h_q     <= h_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            col_q   <= col_d;
        end
    end

    assign last_col = (cx_q == w_q - 1'b1);
    assign last_row = (cy_q == h_q - 1'b1);

    always_comb begin
        state_d = state_q;
        x0_d    = x0_q;
        y0_d    = y0_q;
        xs_d    = xs_q;
        ys_d    = ys_q;
        w_d     = w_q;
        h_d     = h_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        col_d   = col_q;

        if (ld_x) x0_d = data_in;
        if (ld_y) y0_d = data_in[Y_W-1:0];

        case (state_q)
            S_IDLE: begin
                if (start_count) begin
                    // snapshot uses pre-edge origin, so a same-edge load only affects the next draw
                    xs_d    = x0_q;
                    ys_d    = y0_q;
                    w_d     = rect_w;
                    h_d     = rect_h;
                    col_d   = colour_in;
                    cx_d    = '0;
                    cy_d    = '0;
                    state_d = (rect_w == '0 || rect_h == '0) ? S_DONE : S_DRAW;
                end
            end
            S_DRAW: begin
                if (last_col) begin
                    cx_d = '0;
                    if (last_row) state_d = S_DONE;
                    else          cy_d    = cy_q + 1'b1;
                end else begin
                    cx_d = cx_q + 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign draw       = (state_q == S_DRAW);
    assign x_sum      = xs_q + cx_q;
    assign y_sum      = ys_q + cy_q;
    assign x_out      = draw ? x_sum : '0;
    assign y_out      = draw ? y_sum : '0;
    assign colour_out = draw ? col_q : '0;
    assign busy       = draw;
    assign done       = (state_q == S_DONE);

`ifdef RECT_CLIP_EN
    assign plot = draw && (32'(x_sum) < 32'(SCREEN_W)) && (32'(y_sum) < 32'(SCREEN_H));
`else
    assign plot = draw;
`endif

endmodule

// File: tb/tb_rect_fill_engine.sv
// Self-checking bench for rect_fill_engine: directed scenarios plus randomized rectangles
// against a row-major pixel model kept in the bench.
module tb_rect_fill_engine;

    logic       clk = 1'b0;
    logic       resetn;
    logic [7:0] data_in;
    logic       ld_x, ld_y, start_count;
    logic [7:0] rect_w;
    logic [6:0] rect_h;
    logic [2:0] colour_in;
    logic [7:0] x_out;
    logic [6:0] y_out;
    logic [2:0] colour_out;
    logic       plot, busy, done;

    int errors = 0;
    int checks = 0;
    int mx0 = 0;
    int my0 = 0;

    rect_fill_engine dut (
        .clk        (clk),
        .resetn     (resetn),
        .data_in    (data_in),
        .ld_x       (ld_x),
        .ld_y       (ld_y),
        .start_count(start_count),
        .rect_w     (rect_w),
        .rect_h     (rect_h),
        .colour_in  (colour_in),
        .x_out      (x_out),
        .y_out      (y_out),
        .colour_out (colour_out),
        .plot       (plot),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic bit exp_plot(input int x, input int y);
`ifdef RECT_CLIP_EN
        return (x < 160) && (y < 120);
`else
        return 1'b1;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mirror origin loads that were sampled at the edge just passed, then release controls
    task automatic apply_loads();
        if (ld_x) mx0 = int'(data_in);
        if (ld_y) my0 = int'(data_in[6:0]);
        ld_x        = 1'b0;
        ld_y        = 1'b0;
        start_count = 1'b0;
    endtask

    task automatic load_origin(input int x, input int y);
        data_in = 8'(x);
        ld_x    = 1'b1;
        tick();
        apply_loads();
        data_in = 8'(y);
        ld_y    = 1'b1;
        tick();
        apply_loads();
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_x"}, 32'(x_out), 0);
        check({tag, "_y"}, 32'(y_out), 0);
        check({tag, "_col"}, 32'(colour_out), 0);
        check({tag, "_plot"}, 32'(plot), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
    endtask

    // draw one rectangle; disturb drives random loads/starts during the draw, poke_at fires
    // ld_x=99 plus start_count at that pixel index
    task automatic run_rect(input int w, input int h, input int c, input bit disturb, input int poke_at);
        int xs, ys, idx;
        xs          = mx0;
        ys          = my0;
        rect_w      = 8'(w);
        rect_h      = 7'(h);
        colour_in   = 3'(c);
        start_count = 1'b1;
        if (disturb) begin
            data_in = 8'($urandom);
            ld_x    = 1'($urandom);
            ld_y    = 1'($urandom);
        end
        tick();
        apply_loads();
        if (disturb) begin
            rect_w    = 8'($urandom);
            rect_h    = 7'($urandom);
            colour_in = 3'($urandom);
        end
        if (w == 0 || h == 0) begin
            check("empty_busy", 32'(busy), 0);
            check("empty_plot", 32'(plot), 0);
            check("empty_done", 32'(done), 1);
            tick();
            check("empty_done_end", 32'(done), 0);
            return;
        end
        idx = 0;
        for (int yy = 0; yy < h; yy++) begin
            for (int xx = 0; xx < w; xx++) begin
                int ex, ey;
                ex = (xs + xx) % 256;
                ey = (ys + yy) % 128;
                check("draw_busy", 32'(busy), 1);
                check("draw_done", 32'(done), 0);
                check("draw_plot", 32'(plot), 32'(exp_plot(ex, ey)));
                check("draw_x", 32'(x_out), ex);
                check("draw_y", 32'(y_out), ey);
                check("draw_col", 32'(colour_out), c);
                if (disturb) begin
                    data_in     = 8'($urandom);
                    ld_x        = 1'($urandom);
                    ld_y        = 1'($urandom);
                    start_count = 1'($urandom);
                end
                if (idx == poke_at) begin
                    data_in     = 8'd99;
                    ld_x        = 1'b1;
                    start_count = 1'b1;
                end
                tick();
                apply_loads();
                idx++;
            end
        end
        check("fin_done", 32'(done), 1);
        check("fin_plot", 32'(plot), 0);
        check("fin_busy", 32'(busy), 0);
        tick();
        check("fin_done_end", 32'(done), 0);
        check("fin_busy_end", 32'(busy), 0);
    endtask

    initial begin
        resetn      = 1'b0;
        data_in     = '0;
        ld_x        = 1'b0;
        ld_y        = 1'b0;
        start_count = 1'b0;
        rect_w      = '0;
        rect_h      = '0;
        colour_in   = '0;
        #1;
        check_idle_outputs("reset");
        tick();
        tick();
        resetn = 1'b1;
        tick();
        check_idle_outputs("post_reset");

        // origin registers come out of reset at zero
        run_rect(1, 1, 6, 1'b0, -1);

        load_origin(10, 20);
        run_rect(2, 2, 5, 1'b0, -1);

        run_rect(0, 4, 2, 1'b0, -1);
        run_rect(3, 0, 2, 1'b0, -1);

        // loads and start during a draw must not disturb it; new x0 shows on the next start
        load_origin(40, 7);
        run_rect(4, 1, 3, 1'b0, 1);
        run_rect(1, 1, 1, 1'b0, -1);

        load_origin(158, 0);
        run_rect(4, 1, 7, 1'b0, -1);

        load_origin(254, 126);
        run_rect(4, 3, 4, 1'b0, -1);

        // asynchronous reset in the middle of a 3x3 draw
        load_origin(3, 4);
        rect_w      = 8'd3;
        rect_h      = 7'd3;
        colour_in   = 3'd6;
        start_count = 1'b1;
        tick();
        apply_loads();
        for (int i = 0; i < 4; i++) begin
            check("pre_abort_x", 32'(x_out), 3 + (i % 3));
            check("pre_abort_y", 32'(y_out), 4 + (i / 3));
            tick();
        end
        #1;
        resetn = 1'b0;
        #1;
        check_idle_outputs("abort");
        @(negedge clk);
        resetn = 1'b1;
        mx0    = 0;
        my0    = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_idle_outputs("after_abort");
        end
        run_rect(2, 1, 5, 1'b0, -1);

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 2) == 0) load_origin($urandom_range(0, 255), $urandom_range(0, 127));
            run_rect($urandom_range(0, 6), $urandom_range(0, 4), $urandom_range(0, 7), 1'b1, -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
